// File: rtl/typing_stats.sv
// Typing-round tracker: captures keys into a word buffer, scores committed words,
// ends the round on time or word count and derives WPM/accuracy with one shared divider.
module typing_stats #(
    parameter int MAX_LEN       = 25,
    parameter int CHAR_W        = 5,
    parameter int LEN_W         = 5,
    parameter int TICKS_PER_SEC = 10,
    parameter int TIME_W        = 11,
    parameter int CNT_W         = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                state,
    input  logic                      mode,
    input  logic [6:0]                target,
    input  logic                      tick,
    input  logic                      key_strobe,
    input  logic [4:0]                key_num,
    input  logic [MAX_LEN*CHAR_W-1:0] word,
    input  logic [LEN_W-1:0]          word_len,
    output logic [MAX_LEN*CHAR_W-1:0] type_buf,
    output logic [LEN_W-1:0]          cursor,
    output logic                      word_done,
    output logic [CNT_W-1:0]          words_typed,
    output logic [CNT_W-1:0]          correct_words,
    output logic [7:0]                wpm,
    output logic [6:0]                acc,
    output logic                      finish
);
    localparam int DIV_W = 2*CNT_W + 8;
    localparam int BIT_W = $clog2(DIV_W);
    localparam logic [1:0]       ST_SELECT = 2'd0;
    localparam logic [1:0]       ST_INGAME = 2'd2;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV_WPM = 2'd1, S_DIV_ACC = 2'd2} stats_state_t;

    logic [CHAR_W-1:0] buf_r      [MAX_LEN];
    logic [CHAR_W-1:0] word_arr_s [MAX_LEN];
    logic [LEN_W-1:0]  cursor_r;
    logic [CNT_W-1:0]  words_typed_r, correct_words_r, correct_chars_r;
    logic [CNT_W-1:0]  total_keys_r, correct_keys_r;
    logic [TIME_W-1:0] elapsed_r;
    logic [6:0]        target_q_r;
    logic              finish_r, word_done_r;
    logic              in_select_s, active_s, fin_cond_s, fin_set_s, start_s;
    logic              is_letter_s, is_bksp_s, is_space_s, match_s;
    logic [CHAR_W-1:0] exp_char_s;

    stats_state_t      stats_r, stats_nxt_s;
    logic              pending_r;
    logic [DIV_W-1:0]  quo_r, dsr_r, quo_nxt_s;
    logic [DIV_W:0]    rem_r, rem_nxt_s, rem_sh_s;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic              last_bit_s;
    logic [CNT_W-1:0]  ck_snap_r, tk_snap_r;
    logic              wpm_zero_r;
    logic [7:0]        wpm_tmp_r, wpm_r;
    logic [6:0]        acc_r;

    // Key decode, round gating and finish condition
    always_comb begin
        in_select_s = (state == ST_SELECT);
        active_s    = (state == ST_INGAME) && !finish_r;
        is_letter_s = (key_num >= 5'd1) && (key_num <= 5'd26);
        is_bksp_s   = (key_num == 5'd27);
        is_space_s  = (key_num == 5'd28);
        if (mode) begin
            fin_cond_s = (words_typed_r == CNT_W'(target_q_r));
        end else begin
            fin_cond_s = (elapsed_r == TIME_W'(target_q_r) * TIME_W'(TICKS_PER_SEC));
        end
        fin_set_s = active_s && fin_cond_s;
        start_s   = (active_s && tick) || fin_set_s;
    end

    // Unpack the expected word, pack the typed buffer and compare the two
    always_comb begin
        type_buf = '0;
        match_s  = (cursor_r == word_len);
        for (int i = 0; i < MAX_LEN; i++) begin
            word_arr_s[i] = word[i*CHAR_W +: CHAR_W];
            type_buf[i*CHAR_W +: CHAR_W] = buf_r[i];
            if ((LEN_W'(i) < word_len) && (buf_r[i] != word_arr_s[i])) begin
                match_s = 1'b0;
            end else begin
                match_s = match_s;
            end
        end
        if (cursor_r < MAX_LEN_L) begin
            exp_char_s = word_arr_s[cursor_r];
        end else begin
            exp_char_s = '0;
        end
    end

    // Round state: buffer, cursor, counters, timer and sticky finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) buf_r[i] <= '0;
            cursor_r        <= '0;
            words_typed_r   <= '0;
            correct_words_r <= '0;
            correct_chars_r <= '0;
            total_keys_r    <= '0;
            correct_keys_r  <= '0;
            elapsed_r       <= '0;
            finish_r        <= 1'b0;
            word_done_r     <= 1'b0;
            target_q_r      <= '0;
        end else if (in_select_s) begin
            for (int i = 0; i < MAX_LEN; i++) buf_r[i] <= '0;
            cursor_r        <= '0;
            words_typed_r   <= '0;
            correct_words_r <= '0;
            correct_chars_r <= '0;
            total_keys_r    <= '0;
            correct_keys_r  <= '0;
            elapsed_r       <= '0;
            finish_r        <= 1'b0;
            word_done_r     <= 1'b0;
            target_q_r      <= target;
        end else begin
            word_done_r <= 1'b0;
            if (fin_set_s) finish_r <= 1'b1;
            if (active_s && tick && (elapsed_r != '1)) elapsed_r <= elapsed_r + TIME_W'(1);
            if (active_s && key_strobe) begin
                if (is_letter_s) begin
                    // A full buffer swallows the key without touching any counter
                    if (cursor_r < MAX_LEN_L) begin
                        buf_r[cursor_r] <= CHAR_W'(key_num);
                        cursor_r        <= cursor_r + LEN_W'(1);
                        total_keys_r    <= total_keys_r + CNT_W'(1);
                        if ((cursor_r < word_len) && (CHAR_W'(key_num) == exp_char_s)) begin
                            correct_keys_r <= correct_keys_r + CNT_W'(1);
                        end
                    end
                end else if (is_bksp_s) begin
                    if (cursor_r != '0) begin
                        buf_r[cursor_r - LEN_W'(1)] <= '0;
                        cursor_r <= cursor_r - LEN_W'(1);
                    end
                end else if (is_space_s) begin
                    if (cursor_r != '0) begin
                        words_typed_r <= words_typed_r + CNT_W'(1);
                        total_keys_r  <= total_keys_r + CNT_W'(1);
                        if (match_s) begin
                            correct_words_r <= correct_words_r + CNT_W'(1);
                            correct_chars_r <= correct_chars_r + CNT_W'(word_len) + CNT_W'(1);
                            correct_keys_r  <= correct_keys_r + CNT_W'(1);
                        end
                        for (int i = 0; i < MAX_LEN; i++) buf_r[i] <= '0;
                        cursor_r    <= '0;
                        word_done_r <= 1'b1;
                    end
                end
            end
        end
    end

    // Stats FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_r <= S_IDLE;
        end else begin
            stats_r <= stats_nxt_s;
        end
    end

    // Restoring divider step and stats FSM next state
    always_comb begin
        rem_sh_s   = {rem_r[DIV_W-1:0], quo_r[DIV_W-1]};
        last_bit_s = (bit_cnt_r == BIT_W'(DIV_W - 1));
        if (rem_sh_s >= {1'b0, dsr_r}) begin
            rem_nxt_s = rem_sh_s - {1'b0, dsr_r};
            quo_nxt_s = {quo_r[DIV_W-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s;
            quo_nxt_s = {quo_r[DIV_W-2:0], 1'b0};
        end
        stats_nxt_s = stats_r;
        if (in_select_s) begin
            stats_nxt_s = S_IDLE;
        end else begin
            case (stats_r)
                S_IDLE:    stats_nxt_s = pending_r ? S_DIV_WPM : S_IDLE;
                S_DIV_WPM: stats_nxt_s = last_bit_s ? S_DIV_ACC : S_DIV_WPM;
                S_DIV_ACC: stats_nxt_s = last_bit_s ? S_IDLE : S_DIV_ACC;
                default:   stats_nxt_s = S_IDLE;
            endcase
        end
    end

    // Divider operands, request merging and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r  <= 1'b0;
            quo_r      <= '0;
            rem_r      <= '0;
            dsr_r      <= '0;
            bit_cnt_r  <= '0;
            ck_snap_r  <= '0;
            tk_snap_r  <= '0;
            wpm_zero_r <= 1'b0;
            wpm_tmp_r  <= '0;
            wpm_r      <= '0;
            acc_r      <= '0;
        end else if (in_select_s) begin
            pending_r <= 1'b0;
            wpm_r     <= '0;
            acc_r     <= '0;
        end else begin
            pending_r <= start_s || (pending_r && (stats_r != S_IDLE));
            case (stats_r)
                S_IDLE: begin
                    // Snapshot every operand now so both divisions see one consistent state
                    if (pending_r) begin
                        quo_r      <= DIV_W'(correct_chars_r) * DIV_W'(60 * TICKS_PER_SEC);
                        dsr_r      <= DIV_W'(elapsed_r) * DIV_W'(5);
                        rem_r      <= '0;
                        bit_cnt_r  <= '0;
                        wpm_zero_r <= (elapsed_r == '0);
                        ck_snap_r  <= correct_keys_r;
                        tk_snap_r  <= total_keys_r;
                    end
                end
                S_DIV_WPM: begin
                    quo_r     <= quo_nxt_s;
                    rem_r     <= rem_nxt_s;
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    if (last_bit_s) begin
                        if (wpm_zero_r) begin
                            wpm_tmp_r <= '0;
                        end else if (|quo_nxt_s[DIV_W-1:8]) begin
                            wpm_tmp_r <= 8'd255;
                        end else begin
                            wpm_tmp_r <= quo_nxt_s[7:0];
                        end
                        quo_r     <= DIV_W'(ck_snap_r) * DIV_W'(100);
                        dsr_r     <= DIV_W'(tk_snap_r);
                        rem_r     <= '0;
                        bit_cnt_r <= '0;
                    end
                end
                S_DIV_ACC: begin
                    quo_r     <= quo_nxt_s;
                    rem_r     <= rem_nxt_s;
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    if (last_bit_s) begin
                        wpm_r <= wpm_tmp_r;
                        acc_r <= (tk_snap_r == '0) ? 7'd100 : quo_nxt_s[6:0];
                    end
                end
                default: begin
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    assign cursor        = cursor_r;
    assign word_done     = word_done_r;
    assign words_typed   = words_typed_r;
    assign correct_words = correct_words_r;
    assign wpm           = wpm_r;
    assign acc           = acc_r;
    assign finish        = finish_r;
endmodule

// File: tb/tb_typing_stats.sv
// Scoreboard bench for typing_stats: stimulus queues expected values, a negedge monitor
// compares them and every word_done pulse against the DUT.
module tb_typing_stats;
    localparam int MAX_LEN = 25;
    localparam int CHAR_W  = 5;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 12;

    localparam int SEL_CURSOR = 0;
    localparam int SEL_WORDS  = 1;
    localparam int SEL_CWORDS = 2;
    localparam int SEL_WPM    = 3;
    localparam int SEL_ACC    = 4;
    localparam int SEL_FINISH = 5;
    localparam int SEL_BUF0   = 6;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [1:0]                state;
    logic                      mode;
    logic [6:0]                target;
    logic                      tick;
    logic                      key_strobe;
    logic [4:0]                key_num;
    logic [MAX_LEN*CHAR_W-1:0] word;
    logic [LEN_W-1:0]          word_len;
    logic [MAX_LEN*CHAR_W-1:0] type_buf;
    logic [LEN_W-1:0]          cursor;
    logic                      word_done;
    logic [CNT_W-1:0]          words_typed;
    logic [CNT_W-1:0]          correct_words;
    logic [7:0]                wpm;
    logic [6:0]                acc;
    logic                      finish;

    always #5 clk = ~clk;

    typing_stats dut (
        .clk(clk), .rst(rst), .state(state), .mode(mode), .target(target),
        .tick(tick), .key_strobe(key_strobe), .key_num(key_num), .word(word),
        .word_len(word_len), .type_buf(type_buf), .cursor(cursor), .word_done(word_done),
        .words_typed(words_typed), .correct_words(correct_words), .wpm(wpm), .acc(acc),
        .finish(finish)
    );

    typedef struct { string name; int sel; int exp; } chk_t;
    typedef struct { int words; int cwords; } wd_t;

    chk_t chk_q[$];
    wd_t  wd_q[$];
    chk_t c_item;
    wd_t  w_item;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic compare(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_val(input int sel);
        case (sel)
            SEL_CURSOR: return int'(cursor);
            SEL_WORDS:  return int'(words_typed);
            SEL_CWORDS: return int'(correct_words);
            SEL_WPM:    return int'(wpm);
            SEL_ACC:    return int'(acc);
            SEL_FINISH: return int'(finish);
            SEL_BUF0:   return (type_buf == '0) ? 1 : 0;
            default:    return -1;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input int exp);
        chk_t c;
        c.name = name; c.sel = sel; c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: drain directed checks and score every word_done pulse
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            c_item = chk_q.pop_front();
            compare(c_item.name, dut_val(c_item.sel), c_item.exp);
        end
        if (word_done) begin
            if (wd_q.size() == 0) begin
                compare("word_done_unexpected", int'(word_done), 0);
            end else begin
                w_item = wd_q.pop_front();
                compare("wd_words_typed", int'(words_typed), w_item.words);
                compare("wd_correct_words", int'(correct_words), w_item.cwords);
                compare("wd_buf_cleared", dut_val(SEL_BUF0), 1);
                compare("wd_cursor", int'(cursor), 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        key_num = k; key_strobe = 1'b1;
        @(posedge clk); #1;
        key_strobe = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic type_cat(input int words, input int cwords);
        wd_t w;
        w.words = words; w.cwords = cwords;
        wd_q.push_back(w);
        press(5'd3); press(5'd1); press(5'd20); press(5'd28);
    endtask

    task automatic select_round(input logic m, input logic [6:0] t);
        state = 2'd0; mode = m; target = t;
        cycles(2);
        state = 2'd2;
    endtask

    initial begin
        rst = 1'b1; state = 2'd0; mode = 1'b1; target = 7'd2; tick = 1'b0;
        key_strobe = 1'b0; key_num = 5'd0; word_len = 5'd3;
        word = '0;
        word[4:0] = 5'd3; word[9:5] = 5'd1; word[14:10] = 5'd20;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_val("rst_cursor", SEL_CURSOR, 0);
        expect_val("rst_words", SEL_WORDS, 0);
        expect_val("rst_wpm", SEL_WPM, 0);
        expect_val("rst_acc", SEL_ACC, 0);
        expect_val("rst_finish", SEL_FINISH, 0);
        expect_val("rst_buf", SEL_BUF0, 1);

        // Word-count round, target 2
        select_round(1'b1, 7'd2);
        type_cat(1, 1);
        type_cat(2, 2);
        expect_val("m1_finish_not_yet", SEL_FINISH, 0);
        cycles(1);
        expect_val("m1_finish", SEL_FINISH, 1);
        press(5'd3);
        expect_val("m1_key_after_finish", SEL_CURSOR, 0);
        cycles(80);
        expect_val("m1_cwords", SEL_CWORDS, 2);
        expect_val("m1_wpm", SEL_WPM, 0);
        expect_val("m1_acc", SEL_ACC, 100);

        // Correction with backspace; backspace is not a counted key, so 4 of 5 are correct
        select_round(1'b0, 7'd100);
        expect_val("sel_finish", SEL_FINISH, 0);
        expect_val("sel_cwords", SEL_CWORDS, 0);
        expect_val("sel_acc", SEL_ACC, 0);
        press(5'd3); press(5'd24); press(5'd27); press(5'd1); press(5'd20);
        expect_val("bk_cursor", SEL_CURSOR, 3);
        wd_q.push_back('{1, 1});
        press(5'd28);
        pulse_tick();
        cycles(80);
        expect_val("bk_acc", SEL_ACC, 80);
        expect_val("bk_wpm_sat", SEL_WPM, 255);

        // Buffer overflow: 26 letters, last one dropped; backspace at empty buffer
        select_round(1'b0, 7'd100);
        press(5'd3); press(5'd1); press(5'd20);
        for (int i = 0; i < 23; i++) press(5'd1);
        expect_val("ovf_cursor", SEL_CURSOR, 25);
        for (int i = 0; i < 25; i++) press(5'd27);
        expect_val("ovf_cursor_empty", SEL_CURSOR, 0);
        press(5'd27);
        expect_val("bksp_at_zero", SEL_CURSOR, 0);
        pulse_tick();
        cycles(80);
        expect_val("ovf_acc", SEL_ACC, 12);
        expect_val("ovf_wpm", SEL_WPM, 0);

        // Time-limit round, 3 s: 40 correct chars over 30 ticks
        select_round(1'b0, 7'd3);
        for (int i = 1; i <= 10; i++) type_cat(i, i);
        for (int i = 0; i < 29; i++) begin
            pulse_tick();
            cycles(80);
        end
        expect_val("m0_finish_29", SEL_FINISH, 0);
        pulse_tick();
        cycles(100);
        expect_val("m0_finish_30", SEL_FINISH, 1);
        expect_val("m0_wpm", SEL_WPM, 160);
        expect_val("m0_acc", SEL_ACC, 100);
        expect_val("m0_cwords", SEL_CWORDS, 10);
        press(5'd3);
        expect_val("m0_key_after_finish", SEL_CURSOR, 0);

        // Target 0 finishes immediately with no keys, then back to SELECT
        select_round(1'b0, 7'd0);
        cycles(100);
        expect_val("t0_finish", SEL_FINISH, 1);
        expect_val("t0_acc", SEL_ACC, 100);
        expect_val("t0_wpm", SEL_WPM, 0);
        state = 2'd0;
        cycles(2);
        expect_val("back_sel_finish", SEL_FINISH, 0);
        expect_val("back_sel_acc", SEL_ACC, 0);
        expect_val("back_sel_words", SEL_WORDS, 0);

        // Reset in the middle of the WPM division
        select_round(1'b0, 7'd100);
        type_cat(1, 1);
        pulse_tick();
        cycles(10);
        rst = 1'b1; state = 2'd1;
        expect_val("midrst_words", SEL_WORDS, 0);
        expect_val("midrst_cwords", SEL_CWORDS, 0);
        expect_val("midrst_wpm", SEL_WPM, 0);
        expect_val("midrst_acc", SEL_ACC, 0);
        cycles(2);
        rst = 1'b0;
        cycles(80);
        expect_val("postrst_wpm", SEL_WPM, 0);
        expect_val("postrst_acc", SEL_ACC, 0);
        expect_val("postrst_finish", SEL_FINISH, 0);

        cycles(2);
        compare("word_done_missing", wd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
